adaptive_threshold_stage: RTL and testbench

- Final stage of the adaptive-thresholding pipeline, directly downstream of box_filter.
- Raster-scans the image, reading each original pixel from the input ROM and its local mean from the middle RAM (written by box_filter).
- Writes a binarised pixel (255/0) to the output RAM, then raises finished.
- Runs when the global sequencer selects its state, after box_filter has finished.

---
 rtl/adaptive_threshold_pkg.sv | 31 +++
 rtl/adaptive_threshold_stage_raster_addr_counter.sv | 52 +++++
 rtl/adaptive_threshold_stage.sv | 131 +++++++++++++
 tb/tb_adaptive_threshold_stage.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/adaptive_threshold_pkg.sv
// Shared constants for the adaptive-thresholding pipeline: image geometry,
// sequencer encodings, pixel levels and the threshold compare.
package adaptive_threshold_pkg;

  localparam int WIDTH_BITS_DEF  = 8;
  localparam int HEIGHT_BITS_DEF = 8;

  localparam logic [2:0] GS_IDLE       = 3'd0;
  localparam logic [2:0] GS_BOX_FILTER = 3'd1;
  localparam logic [2:0] GS_THRESHOLD  = 3'd2;
  localparam logic [2:0] GS_OUTPUT     = 3'd3;

  localparam logic [7:0] PIX_WHITE = 8'd255;
  localparam logic [7:0] PIX_BLACK = 8'd0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } stage_state_e;

  // Widened to 9 bits so pixel + offset can never wrap.
  function automatic logic is_white(input logic [7:0] pix,
                                    input logic [7:0] mean,
                                    input logic [7:0] offset);
    logic [8:0] sum;
    sum = {1'b0, pix} + {1'b0, offset};
    return sum > {1'b0, mean};
  endfunction

endpackage

// File: rtl/adaptive_threshold_stage_raster_addr_counter.sv
// Raster column/row counter: column runs fastest, wraps into the row.
// clear has priority over enable; last flags the final (W-1,H-1) address.
module raster_addr_counter #(
  parameter int WIDTH_BITS  = 8,
  parameter int HEIGHT_BITS = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   enable,
  output logic [WIDTH_BITS-1:0]  col,
  output logic [HEIGHT_BITS-1:0] row,
  output logic                   last
);

  localparam logic [WIDTH_BITS-1:0]  COL_ONE = 1;
  localparam logic [HEIGHT_BITS-1:0] ROW_ONE = 1;

  logic [WIDTH_BITS-1:0]  col_q, col_d;
  logic [HEIGHT_BITS-1:0] row_q, row_d;

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (clear) begin
      col_d = '0;
      row_d = '0;
    end else if (enable) begin
      if (col_q == '1) begin
        col_d = '0;
        row_d = row_q + ROW_ONE;
      end else begin
        col_d = col_q + COL_ONE;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  assign col  = col_q;
  assign row  = row_q;
  assign last = (col_q == '1) && (row_q == '1);

endmodule

// File: rtl/adaptive_threshold_stage.sv
// Binarises each pixel against its local mean: S0 issues the address, S1
// receives ROM/RAM data, S2 registers the write. finished follows the last write.
module adaptive_threshold_stage
  import adaptive_threshold_pkg::*;
#(
  parameter int         WIDTH_BITS   = WIDTH_BITS_DEF,
  parameter int         HEIGHT_BITS  = HEIGHT_BITS_DEF,
  parameter logic [7:0] OFFSET       = 8'd7,
  parameter logic [2:0] ACTIVE_STATE = GS_THRESHOLD
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [2:0]             global_state,
  output logic [WIDTH_BITS-1:0]  oImageCol,
  output logic [HEIGHT_BITS-1:0] oImageRow,
  input  logic [7:0]             iImageData,
  output logic [WIDTH_BITS-1:0]  oMeanCol,
  output logic [HEIGHT_BITS-1:0] oMeanRow,
  input  logic [7:0]             iMeanData,
  output logic [WIDTH_BITS-1:0]  oResultCol,
  output logic [HEIGHT_BITS-1:0] oResultRow,
  output logic [7:0]             oResultData,
  output logic                   oResultWren,
  output logic                   finished
);

  stage_state_e state_q, state_d;
  logic                   issue_done_q, issue_done_d;
  logic                   s1_valid_q, s1_valid_d;
  logic [WIDTH_BITS-1:0]  s1_col_q, s1_col_d;
  logic [HEIGHT_BITS-1:0] s1_row_q, s1_row_d;
  logic                   wren_q, wren_d;
  logic [WIDTH_BITS-1:0]  res_col_q, res_col_d;
  logic [HEIGHT_BITS-1:0] res_row_q, res_row_d;
  logic [7:0]             res_data_q, res_data_d;
  logic                   finished_q, finished_d;

  logic                   active, run_stay, s0_valid;
  logic                   cnt_clr, cnt_en, cnt_last;
  logic [WIDTH_BITS-1:0]  cnt_col;
  logic [HEIGHT_BITS-1:0] cnt_row;

  raster_addr_counter #(
    .WIDTH_BITS (WIDTH_BITS),
    .HEIGHT_BITS(HEIGHT_BITS)
  ) u_addr (
    .clock (clock),
    .reset (reset),
    .clear (cnt_clr),
    .enable(cnt_en),
    .col   (cnt_col),
    .row   (cnt_row),
    .last  (cnt_last)
  );

  always_comb begin
    active   = (global_state == ACTIVE_STATE);
    run_stay = (state_q == ST_RUN) && active;
    s0_valid = run_stay && !issue_done_q;
    // Hold the counter on the final address instead of wrapping to (0,0).
    cnt_en   = s0_valid && !cnt_last;
    cnt_clr  = (state_q != ST_RUN);

    issue_done_d = (state_q == ST_RUN) && (issue_done_q || (s0_valid && cnt_last));
    s1_valid_d   = s0_valid;
    s1_col_d     = cnt_col;
    s1_row_d     = cnt_row;
    wren_d       = run_stay && s1_valid_q;

    res_col_d  = res_col_q;
    res_row_d  = res_row_q;
    res_data_d = res_data_q;
    if (run_stay && s1_valid_q) begin
      res_col_d  = s1_col_q;
      res_row_d  = s1_row_q;
      res_data_d = is_white(iImageData, iMeanData, OFFSET) ? PIX_WHITE : PIX_BLACK;
    end

    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (active) state_d = ST_RUN;
      ST_RUN: begin
        if (!active)
          state_d = ST_IDLE;
        else if (wren_q && (res_col_q == '1) && (res_row_q == '1))
          state_d = ST_DONE;
      end
      ST_DONE: if (!active) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    finished_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      issue_done_q <= 1'b0;
      s1_valid_q   <= 1'b0;
      s1_col_q     <= '0;
      s1_row_q     <= '0;
      wren_q       <= 1'b0;
      res_col_q    <= '0;
      res_row_q    <= '0;
      res_data_q   <= '0;
      finished_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      issue_done_q <= issue_done_d;
      s1_valid_q   <= s1_valid_d;
      s1_col_q     <= s1_col_d;
      s1_row_q     <= s1_row_d;
      wren_q       <= wren_d;
      res_col_q    <= res_col_d;
      res_row_q    <= res_row_d;
      res_data_q   <= res_data_d;
      finished_q   <= finished_d;
    end
  end

  assign oImageCol   = cnt_col;
  assign oImageRow   = cnt_row;
  assign oMeanCol    = cnt_col;
  assign oMeanRow    = cnt_row;
  assign oResultCol  = res_col_q;
  assign oResultRow  = res_row_q;
  assign oResultData = res_data_q;
  // Gating by RUN kills a pending write the moment an abort takes effect.
  assign oResultWren = wren_q && (state_q == ST_RUN);
  assign finished    = finished_q;

endmodule

// File: tb/tb_adaptive_threshold_stage.sv
// Scoreboard bench for adaptive_threshold_stage on a reduced 16x8 image:
// expected writes are queued per frame and popped by a negedge monitor.
module tb_adaptive_threshold_stage;

  localparam int WB  = 4;
  localparam int HB  = 3;
  localparam int W   = 16;
  localparam int H   = 8;
  localparam int N   = W * H;
  localparam int OFS = 7;

  logic          clock = 1'b0;
  logic          reset;
  logic [2:0]    global_state;
  logic [WB-1:0] oImageCol, oMeanCol, oResultCol;
  logic [HB-1:0] oImageRow, oMeanRow, oResultRow;
  logic [7:0]    iImageData, iMeanData, oResultData;
  logic          oResultWren, finished;

  adaptive_threshold_stage #(
    .WIDTH_BITS  (WB),
    .HEIGHT_BITS (HB),
    .OFFSET      (8'd7),
    .ACTIVE_STATE(3'd2)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .global_state(global_state),
    .oImageCol   (oImageCol),
    .oImageRow   (oImageRow),
    .iImageData  (iImageData),
    .oMeanCol    (oMeanCol),
    .oMeanRow    (oMeanRow),
    .iMeanData   (iMeanData),
    .oResultCol  (oResultCol),
    .oResultRow  (oResultRow),
    .oResultData (oResultData),
    .oResultWren (oResultWren),
    .finished    (finished)
  );

  always #5 clock = ~clock;

  logic [7:0] img_mem [N];
  logic [7:0] mean_mem[N];

  // Synchronous-read memories: data appears one cycle after the address.
  always @(posedge clock) begin
    iImageData <= img_mem[{oImageRow, oImageCol}];
    iMeanData  <= mean_mem[{oMeanRow, oMeanCol}];
  end

  typedef struct {
    int col;
    int row;
    int data;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   wr_count, first_wr_cyc, last_wr_cyc, fin_cyc, run_len;
  bit   prev_wren = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (oResultWren) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write got (%0d,%0d)=%0d want no write",
                 oResultCol, oResultRow, oResultData);
      end else begin
        mon_e = exp_q.pop_front();
        if (oResultCol != mon_e.col || oResultRow != mon_e.row || oResultData != mon_e.data) begin
          failures++;
          $display("FAIL write got (%0d,%0d)=%0d want (%0d,%0d)=%0d",
                   oResultCol, oResultRow, oResultData, mon_e.col, mon_e.row, mon_e.data);
        end
      end
      checks++;
      if (finished) begin
        failures++;
        $display("FAIL finished_with_wren got finished=1 want 0");
      end
      wr_count++;
      if (first_wr_cyc < 0) first_wr_cyc = cyc;
      last_wr_cyc = cyc;
      run_len = prev_wren ? run_len + 1 : 1;
    end
    if (finished && fin_cyc < 0) fin_cyc = cyc;
    prev_wren = oResultWren;
  end

  function automatic int model(int pix, int mean);
    return (pix + OFS > mean) ? 255 : 0;
  endfunction

  task automatic check(string name, int got, int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  task automatic step();
    @(negedge clock);
    #1;
  endtask

  task automatic clr_mon();
    wr_count     = 0;
    first_wr_cyc = -1;
    last_wr_cyc  = -1;
    fin_cyc      = -1;
    run_len      = 0;
  endtask

  task automatic fill(int mode);
    int bp[6] = '{50, 51, 255, 0, 248, 249};
    int bm[6] = '{57, 57, 255, 255, 255, 255};
    for (int i = 0; i < N; i++) begin
      case (mode)
        0: begin img_mem[i] = 8'd100; mean_mem[i] = 8'd100; end
        1: begin
          if (i < 60) begin
            img_mem[i]  = 8'(bp[i % 6]);
            mean_mem[i] = 8'(bm[i % 6]);
          end else begin
            img_mem[i]  = 8'($urandom_range(0, 255));
            mean_mem[i] = 8'(int'(img_mem[i]) + $urandom_range(0, 14) > 255 ? 255 :
                             int'(img_mem[i]) + $urandom_range(0, 14));
          end
        end
        default: begin
          img_mem[i]  = 8'($urandom_range(0, 255));
          mean_mem[i] = 8'($urandom_range(0, 255));
        end
      endcase
    end
  endtask

  // Expected output of a whole frame in raster order, from the threshold rule.
  task automatic push_frame();
    exp_q.delete();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        exp_q.push_back('{c, r, model(int'(img_mem[r*W + c]), int'(mean_mem[r*W + c]))});
  endtask

  task automatic wait_frame(string tag, int start);
    step();
    check({tag, "_first_addr"}, {oImageRow, oImageCol}, 0);
    for (int i = 0; i < N + 20 && fin_cyc < 0; i++) step();
    check({tag, "_finished_seen"}, int'(fin_cyc >= 0), 1);
    check({tag, "_first_write_latency"}, first_wr_cyc - start, 3);
    check({tag, "_write_count"}, wr_count, N);
    check({tag, "_contiguous_run"}, run_len, N);
    check({tag, "_finish_delay"}, fin_cyc - last_wr_cyc, 1);
    check({tag, "_queue_empty"}, exp_q.size(), 0);
    step();
    check({tag, "_finished_hold"}, int'(finished), 1);
    global_state = 3'd0;
    step();
    check({tag, "_finished_clear"}, int'(finished), 0);
  endtask

  task automatic run_full_frame(string tag);
    int start;
    push_frame();
    clr_mon();
    start = cyc;
    global_state = 3'd2;
    wait_frame(tag, start);
  endtask

  task automatic check_zero_outputs(string tag);
    check({tag, "_wren"}, int'(oResultWren), 0);
    check({tag, "_finished"}, int'(finished), 0);
    check({tag, "_res_addr"}, {oResultRow, oResultCol}, 0);
    check({tag, "_res_data"}, oResultData, 0);
    check({tag, "_img_addr"}, {oImageRow, oImageCol}, 0);
    check({tag, "_mean_addr"}, {oMeanRow, oMeanCol}, 0);
  endtask

  initial begin
    int start;
    reset = 1'b1;
    global_state = 3'd0;
    fill(0);
    clr_mon();
    repeat (3) step();
    check_zero_outputs("reset");
    reset = 1'b0;
    step();

    // Other sequencer states must not start the stage.
    global_state = 3'd1;
    repeat (8) step();
    global_state = 3'd3;
    repeat (8) step();
    check("idle_no_writes", wr_count, 0);
    check("idle_no_finished", int'(finished), 0);
    global_state = 3'd0;
    step();

    fill(0);
    run_full_frame("uniform");
    fill(1);
    run_full_frame("boundary");
    fill(2);
    run_full_frame("random");

    // Abort partway through a frame.
    fill(2);
    push_frame();
    clr_mon();
    global_state = 3'd2;
    for (int i = 0; i < N && wr_count < 40; i++) step();
    check("abort_reached", wr_count, 40);
    global_state = 3'd0;
    step();
    check("abort_wren_drop", int'(oResultWren), 0);
    repeat (6) step();
    check("abort_no_more_writes", wr_count, 40);
    check("abort_finished_low", int'(finished), 0);
    fill(2);
    run_full_frame("after_abort");

    // Reset pulse in the middle of a run.
    fill(2);
    push_frame();
    clr_mon();
    global_state = 3'd2;
    repeat (30) step();
    reset = 1'b1;
    #1;
    check_zero_outputs("midrun_reset");
    step();
    push_frame();
    clr_mon();
    start = cyc;
    reset = 1'b0;
    wait_frame("after_reset", start);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
